// File: rtl/ascii_hex_loader.sv
// ASCII hex text loader: parses whitespace-separated hex words from a byte
// stream and writes them to consecutive memory word addresses.
module ascii_hex_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [2:0] S_SCAN    = 3'd0;
    localparam logic [2:0] S_DIGIT   = 3'd1;
    localparam logic [2:0] S_COMMENT = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] E_ILLEGAL = 2'd1;
    localparam logic [1:0] E_LENGTH  = 2'd2;
    localparam logic [1:0] E_FULL    = 2'd3;

    logic [2:0]        state;
    logic [31:0]       acc;
    logic [3:0]        digit_cnt;
    logic [ADDR_W-1:0] addr;

    logic       is_hex;
    logic       is_sep;
    logic       is_hash;
    logic       is_eot;
    logic       is_lf;
    logic [3:0] nibble;
    logic       accept;

    always_comb begin
        is_hex = 1'b0;
        nibble = '0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = in_data[3:0];
        end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                     (in_data >= 8'h61 && in_data <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = in_data[3:0] + 4'd9;
        end
        is_lf   = (in_data == 8'h0A);
        is_sep  = (in_data == 8'h20) || (in_data == 8'h09) ||
                  (in_data == 8'h0D) || is_lf;
        is_hash = (in_data == 8'h23);
        is_eot  = (in_data == 8'h04);
    end

    assign in_ready = !rst && (state == S_SCAN || state == S_DIGIT || state == S_COMMENT);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_SCAN;
            acc        <= '0;
            digit_cnt  <= '0;
            addr       <= BASE;
            word_count <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE;
            wr_data    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    S_SCAN: begin
                        if (is_hex) begin
                            acc       <= {28'd0, nibble};
                            digit_cnt <= 4'd1;
                            state     <= S_DIGIT;
                        end else if (is_sep) begin
                            state <= S_SCAN;
                        end else if (is_hash) begin
                            state <= S_COMMENT;
                        end else if (is_eot) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= E_ILLEGAL;
                        end
                    end
                    S_DIGIT: begin
                        if (is_hex) begin
                            if (digit_cnt == 4'd8) begin
                                state    <= S_ERROR;
                                error    <= 1'b1;
                                err_code <= E_LENGTH;
                            end else begin
                                acc       <= {acc[27:0], nibble};
                                digit_cnt <= digit_cnt + 4'd1;
                            end
                        end else if (is_sep || is_hash || is_eot) begin
                            // Capacity is checked at flush time so a full memory is never overwritten.
                            if (word_count == CAPACITY) begin
                                state    <= S_ERROR;
                                error    <= 1'b1;
                                err_code <= E_FULL;
                            end else begin
                                wr_en      <= 1'b1;
                                wr_addr    <= addr;
                                wr_data    <= acc;
                                addr       <= addr + ADDR_ONE;
                                word_count <= word_count + CNT_ONE;
                                acc        <= '0;
                                digit_cnt  <= '0;
                                if (is_sep) begin
                                    state <= S_SCAN;
                                end else if (is_hash) begin
                                    state <= S_COMMENT;
                                end else begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end
                            end
                        end else begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= E_ILLEGAL;
                            acc      <= '0;
                            digit_cnt <= '0;
                        end
                    end
                    S_COMMENT: begin
                        if (is_lf) begin
                            state <= S_SCAN;
                        end else if (is_eot) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ascii_hex_loader.sv
// Bench for ascii_hex_loader: table of text images plus hand-written timing
// sequences; writes are checked against a queue of expected writes.
module tb_ascii_hex_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        m_valid = 1'b0;
    logic [7:0]  m_data  = 8'h00;
    logic        m_ready, m_wr_en, m_done, m_err;
    logic [9:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    logic [10:0] m_count;
    logic [1:0]  m_code;

    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_ready, s_wr_en, s_done, s_err;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_count;
    logic [1:0]  s_code;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t m_q[$];
    wr_t s_q[$];

    typedef struct {
        string       text;
        bit          eot;
        int          n_wr;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          exp_done;
        bit          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[8];

    ascii_hex_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_main (
        .clk(clk), .rst(rst), .in_valid(m_valid), .in_data(m_data),
        .in_ready(m_ready), .wr_en(m_wr_en), .wr_addr(m_wr_addr),
        .wr_data(m_wr_data), .word_count(m_count), .done(m_done),
        .error(m_err), .err_code(m_code)
    );

    ascii_hex_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
        .in_ready(s_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
        .wr_data(s_wr_data), .word_count(s_count), .done(s_done),
        .error(s_err), .err_code(s_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_wr_en === 1'b1) begin
            if (m_q.size() == 0) begin
                check("m_unexpected_write", {22'd0, m_wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = m_q.pop_front();
                check("m_wr_addr", {22'd0, m_wr_addr}, {22'd0, e.addr});
                check("m_wr_data", m_wr_data, e.data);
            end
        end
        if (s_wr_en === 1'b1) begin
            if (s_q.size() == 0) begin
                check("s_unexpected_write", {30'd0, s_wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = s_q.pop_front();
                check("s_wr_addr", {30'd0, s_wr_addr}, {22'd0, e.addr});
                check("s_wr_data", s_wr_data, e.data);
            end
        end
    end

    task automatic send_m(input logic [7:0] c);
        @(negedge clk);
        m_valid = 1'b1;
        m_data  = c;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    task automatic send_s(input logic [7:0] c);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = c;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_str_m(input string s);
        for (int i = 0; i < s.len(); i++) send_m(s[i]);
    endtask

    task automatic send_str_s(input string s);
        for (int i = 0; i < s.len(); i++) send_s(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, m_ready}, 32'd0);
        check("rst_wr_en", {31'd0, m_wr_en}, 32'd0);
        check("rst_wr_addr", {22'd0, m_wr_addr}, 32'd0);
        check("rst_wr_data", m_wr_data, 32'd0);
        check("rst_count", {21'd0, m_count}, 32'd0);
        check("rst_flags", {28'd0, m_done, m_err, m_code}, 32'd0);
        check("rst_s_count", {29'd0, s_count}, 32'd0);
        check("m_q_empty_at_rst", m_q.size(), 32'd0);
        check("s_q_empty_at_rst", s_q.size(), 32'd0);
        m_q.delete();
        s_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, m_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{"deadbeef\n12\n", 1'b1, 2, 32'hDEADBEEF, 32'h00000012, 1'b1, 1'b0, 2'd0};
        vecs[1] = '{"123456789", 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd2};
        vecs[2] = '{"ABG", 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 2'd1};
        vecs[3] = '{"# x 55 ZZ\nab", 1'b1, 1, 32'h000000AB, 32'h0, 1'b1, 1'b0, 2'd0};
        vecs[4] = '{"  7fFfFfFf\t0\r\n", 1'b1, 2, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 2'd0};
        vecs[5] = '{"12 @", 1'b0, 1, 32'h00000012, 32'h0, 1'b0, 1'b1, 2'd1};
        vecs[6] = '{"a#b\nc", 1'b1, 2, 32'h0000000A, 32'h0000000C, 1'b1, 1'b0, 2'd0};
        vecs[7] = '{"", 1'b1, 0, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0};

        rst = 1'b1;
        idle(2);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int k = 0; k < vecs[v].n_wr; k++)
                m_q.push_back('{addr: 10'(k), data: (k == 0) ? vecs[v].w0 : vecs[v].w1});
            send_str_m(vecs[v].text);
            if (vecs[v].eot) send_m(8'h04);
            idle(3);
            check($sformatf("v%0d_done", v), {31'd0, m_done}, {31'd0, vecs[v].exp_done});
            check($sformatf("v%0d_error", v), {31'd0, m_err}, {31'd0, vecs[v].exp_err});
            check($sformatf("v%0d_code", v), {30'd0, m_code}, {30'd0, vecs[v].exp_code});
            check($sformatf("v%0d_count", v), {21'd0, m_count}, 32'(vecs[v].n_wr));
            check($sformatf("v%0d_pending", v), m_q.size(), 32'd0);
        end

        // write strobe lands exactly one cycle after the terminator
        do_reset();
        m_q.push_back('{addr: 10'd0, data: 32'hDEADBEEF});
        send_str_m("deadbeef");
        check("no_wr_before_lf", {31'd0, m_wr_en}, 32'd0);
        send_m(8'h0A);
        check("wr_cycle_after_lf", {31'd0, m_wr_en}, 32'd1);
        idle(1);
        check("wr_one_cycle", {31'd0, m_wr_en}, 32'd0);
        check("count_after_one", {21'd0, m_count}, 32'd1);

        // ninth digit errors on the following cycle
        do_reset();
        send_str_m("12345678");
        check("no_err_at_8", {31'd0, m_err}, 32'd0);
        send_m("9");
        check("err_after_9", {29'd0, m_err, m_code}, 32'b110);
        check("ready_low_in_error", {31'd0, m_ready}, 32'd0);

        // final write and done in the same cycle
        do_reset();
        m_q.push_back('{addr: 10'd0, data: 32'h000000AB});
        send_str_m("# x 55 ZZ\nab");
        send_m(8'h04);
        check("eot_wr_and_done", {30'd0, m_wr_en, m_done}, 32'b11);
        check("eot_no_err", {31'd0, m_err}, 32'd0);
        idle(1);
        check("ready_low_in_done", {31'd0, m_ready}, 32'd0);

        // capacity on the 4-word instance
        do_reset();
        for (int k = 0; k < 4; k++)
            s_q.push_back('{addr: 10'(k), data: 32'(k + 1)});
        send_str_s("1 2 3 4 5");
        send_s(8'h20);
        check("full_no_wr", {31'd0, s_wr_en}, 32'd0);
        check("full_err", {28'd0, s_done, s_err, s_code}, 32'b0111);
        check("full_count", {29'd0, s_count}, 32'd4);
        idle(2);
        check("full_pending", s_q.size(), 32'd0);

        // reset mid-word discards the partial word
        do_reset();
        send_m("A");
        idle(2);
        send_m("B");
        idle(3);
        send_m("C");
        idle(1);
        do_reset();
        m_q.push_back('{addr: 10'd0, data: 32'h00000001});
        send_str_m("1\n");
        idle(2);
        check("midrst_count", {21'd0, m_count}, 32'd1);
        check("midrst_pending", m_q.size(), 32'd0);
        check("midrst_flags", {29'd0, m_done, m_err, m_ready}, 32'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
